uart_rx: RTL and testbench

//  Serial receiver paired with the UART transmitter on the same clock: consumes the TX_OUT line,

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive port bundle: line and parity controls in, received byte and status pulses out.
interface uart_rx_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART frame receiver (start, 8 data LSB first, optional parity, stop). Status pulses land
// SYNC_STAGES+1 clocks after the stop-bit sample point; no backpressure, each frame reported once.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic rx_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = bus.RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= bus.RX_IN;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_en_q, par_en_d;
  logic          par_typ_q, par_typ_d;
  logic          pbit_q, pbit_d;
  logic          stop_q, stop_d;
  logic          done_q, done_d;
  logic [7:0]    p_data_q, p_data_d;
  logic          dv_q, dv_d;
  logic          pe_q, pe_d;
  logic          se_q, se_d;

  logic at_mid, bit_end, exp_par, par_bad;

  assign at_mid  = (cnt_q == CNT_MID);
  assign bit_end = (cnt_q == CNT_LAST);
  assign exp_par = par_typ_q ? (^shreg_q) : (~^shreg_q);
  assign par_bad = par_en_q & (pbit_q != exp_par);

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + CNT_ONE;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    pbit_d    = pbit_q;
    stop_d    = stop_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          // The detection cycle is clock 0 of the start bit; one clock per bit skips START entirely.
          if (CLKS_PER_BIT == 1) begin
            state_d = DATA;
          end else begin
            state_d = START;
            cnt_d   = CNT_ONE;
          end
        end
      end
      START: begin
        if (at_mid && rx_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (at_mid) shreg_d[bit_idx_q] = rx_s;
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (at_mid) pbit_d = rx_s;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Leave at the sample point so a back-to-back start bit is caught on its first low clock.
        if (at_mid) begin
          stop_d  = rx_s;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    p_data_d = done_q ? shreg_q : p_data_q;
    pe_d     = done_q & par_bad;
    se_d     = done_q & ~stop_q;
    dv_d     = done_q & ~par_bad & stop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pbit_q    <= 1'b0;
      stop_q    <= 1'b1;
      done_q    <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      pbit_q    <= pbit_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.PAR_ERR    = pe_q;
  assign bus.STP_ERR    = se_q;
  assign bus.Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Drives directed and random frames into a 1-clock-per-bit and a 16-clock-per-bit receiver and
// compares every status pulse (byte, flags, arrival cycle) against a frame-level reference.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if b1();
  uart_rx_if b16();

  uart_rx #(.CLKS_PER_BIT(1),  .SYNC_STAGES(SYNC)) dut1  (.clk(clk), .reset(reset), .bus(b1));
  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(SYNC)) dut16 (.clk(clk), .reset(reset), .bus(b16));

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic       pe;
    logic       se;
    int         cyc;
  } rec_t;

  rec_t obs1[$], obs16[$], exp1[$], exp16[$];

  always @(negedge clk) begin
    rec_t r;
    if (b1.DATA_VALID || b1.PAR_ERR || b1.STP_ERR) begin
      r.d = b1.P_DATA; r.dv = b1.DATA_VALID; r.pe = b1.PAR_ERR; r.se = b1.STP_ERR; r.cyc = cyc;
      obs1.push_back(r);
    end
    if (b16.DATA_VALID || b16.PAR_ERR || b16.STP_ERR) begin
      r.d = b16.P_DATA; r.dv = b16.DATA_VALID; r.pe = b16.PAR_ERR; r.se = b16.STP_ERR; r.cyc = cyc;
      obs16.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic good_par(input logic [7:0] d, input logic ptyp);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    // even type: bit makes total ones even -> bit = ones odd; odd type: the opposite
    return ptyp ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  task automatic put(input int inst, input logic b, input int n);
    if (inst == 1) b1.RX_IN = b;
    else b16.RX_IN = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int inst, input logic [7:0] d, input logic pen, input logic ptyp,
                      input logic pbit, input logic stop, input int gap, input logic flip);
    int   cpb;
    rec_t e;
    cpb = (inst == 1) ? 1 : 16;
    if (inst == 1) begin b1.PAR_EN = pen; b1.PAR_TYP = ptyp; end
    else begin b16.PAR_EN = pen; b16.PAR_TYP = ptyp; end
    put(inst, 1'b0, cpb);
    if (flip) begin
      if (inst == 1) begin b1.PAR_EN = ~pen; b1.PAR_TYP = ~ptyp; end
      else begin b16.PAR_EN = ~pen; b16.PAR_TYP = ~ptyp; end
    end
    for (int i = 0; i < 8; i++) put(inst, d[i], cpb);
    if (pen) put(inst, pbit, cpb);
    e.cyc = cyc + 1 + cpb / 2 + SYNC + 1;
    put(inst, stop, cpb);
    e.d  = d;
    e.pe = pen && (pbit != good_par(d, ptyp));
    e.se = !stop;
    e.dv = !e.pe && !e.se;
    if (inst == 1) exp1.push_back(e);
    else exp16.push_back(e);
    if (gap > 0) put(inst, 1'b1, gap * cpb);
  endtask

  task automatic drain(input int inst, input string tag);
    rec_t o[$], x[$];
    int   n;
    repeat (24) @(negedge clk);
    if (inst == 1) begin o = obs1; x = exp1; obs1.delete(); exp1.delete(); end
    else begin o = obs16; x = exp16; obs16.delete(); exp16.delete(); end
    chk($sformatf("%s.count", tag), o.size(), x.size());
    n = (o.size() < x.size()) ? o.size() : x.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].data", tag, i), o[i].d, x[i].d);
      chk($sformatf("%s[%0d].flags", tag, i), {o[i].dv, o[i].pe, o[i].se}, {x[i].dv, x[i].pe, x[i].se});
      chk($sformatf("%s[%0d].cycle", tag, i), o[i].cyc, x[i].cyc);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       pen, ptyp, pbit, stop;
    int         gap;

    b1.RX_IN = 1'b1;  b1.PAR_EN = 1'b0;  b1.PAR_TYP = 1'b0;
    b16.RX_IN = 1'b1; b16.PAR_EN = 1'b0; b16.PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.p_data", b1.P_DATA, 8'h00);
    chk("reset.flags", {b1.DATA_VALID, b1.PAR_ERR, b1.STP_ERR}, 3'b000);
    chk("reset.busy", b1.Busy, 1'b0);
    chk("reset16.p_data", b16.P_DATA, 8'h00);
    chk("reset16.busy", b16.Busy, 1'b0);

    send(1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    drain(1, "odd_good");
    send(1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    drain(1, "odd_bad");
    chk("held.p_data", b1.P_DATA, 8'hA5);
    send(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    send(1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    drain(1, "stop_err");

    put(16, 1'b0, 4);
    chk("glitch.busy_hi", b16.Busy, 1'b1);
    put(16, 1'b1, 16);
    chk("glitch.busy_lo", b16.Busy, 1'b0);
    drain(16, "glitch");
    send(16, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    send(16, 8'h5A, 1'b1, 1'b0, good_par(8'h5A, 1'b0), 1'b1, 1, 1'b1);
    drain(16, "cpb16");

    send(1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send(1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    drain(1, "b2b");

    put(1, 1'b0, 1);
    put(1, 1'b0, 5);
    reset = 1'b1;
    put(1, 1'b0, 1);
    reset = 1'b0;
    b1.RX_IN = 1'b1;
    chk("midreset.busy", b1.Busy, 1'b0);
    chk("midreset.p_data", b1.P_DATA, 8'h00);
    put(1, 1'b1, 20);
    drain(1, "midreset");
    send(1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    drain(1, "after_reset");

    for (int i = 0; i < 20; i++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = good_par(d, ptyp) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      gap  = (i == 19) ? 2 : int'($urandom_range(0, 3));
      send(1, d, pen, ptyp, pbit, stop, gap, 1'b0);
    end
    drain(1, "rand1");

    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = good_par(d, ptyp) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      send(16, d, pen, ptyp, pbit, stop, int'($urandom_range(1, 2)), 1'b0);
    end
    drain(16, "rand16");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
